// File: rtl/rsa_pkg.sv
// rsa_pkg: shared RSA datapath width and arbiter state encoding
package rsa_pkg;
  localparam int RSA_WIDTH = 256;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, first set bit of req at or above ptr (cyclic)
//   req : per-requester request levels
//   ptr : highest-priority requester index
//   gnt : one-hot winner (zero when req is zero)
//   idx : winner index (zero when req is zero)
module rr_picker #(
  parameter int N_REQ = 2,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
)(
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    // scan from the farthest offset down so the nearest requester overwrites last
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        gnt = N_REQ'(1) << ((int'(ptr) + i) % N_REQ);
        idx = IW'((int'(ptr) + i) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/mont_arbiter.sv
// mont_arbiter: round-robin sharing of one Montgomery multiplier between N_REQ requesters
//   i_req/i_a/i_b/i_n : requests and packed operands (requester k at [k*WIDTH +: WIDTH])
//   o_gnt             : one-cycle pulse, operands of that requester captured
//   o_done/o_err      : one-cycle completion pulse, error flag on timeout
//   o_result          : last result, held until the next completion
//   o_busy            : operation in flight
//   o_mont_*          : start pulse and registered operands to the multiplier
//   i_mont_result/i_mont_finish : multiplier response
module mont_arbiter
  import rsa_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = RSA_WIDTH,
  parameter int TIMEOUT = 1023
)(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_a,
  input  logic [N_REQ*WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0]       i_n,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_err,
  output logic [WIDTH-1:0]       o_result,
  output logic                   o_busy,
  output logic                   o_mont_start,
  output logic [WIDTH-1:0]       o_mont_a,
  output logic [WIDTH-1:0]       o_mont_b,
  output logic [WIDTH-1:0]       o_mont_n,
  input  logic [WIDTH-1:0]       i_mont_result,
  input  logic                   i_mont_finish
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IW-1:0] rr_ptr, owner, pick_idx;
  logic [N_REQ-1:0] pick_gnt, owner_oh;
  logic [TW-1:0] timer;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req(i_req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  assign owner_oh = N_REQ'(1) << owner;
  assign o_busy = state != S_IDLE;
  // o_mont_start is raised together with o_gnt so it is high for the whole S_ISSUE cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      timer        <= '0;
      o_gnt        <= '0;
      o_done       <= '0;
      o_err        <= 1'b0;
      o_result     <= '0;
      o_mont_start <= 1'b0;
      o_mont_a     <= '0;
      o_mont_b     <= '0;
      o_mont_n     <= '0;
    end else begin
      o_gnt        <= '0;
      o_done       <= '0;
      o_err        <= 1'b0;
      o_mont_start <= 1'b0;
      case (state)
        S_IDLE: if (|i_req) begin
          o_mont_a     <= i_a[int'(pick_idx) * WIDTH +: WIDTH];
          o_mont_b     <= i_b[int'(pick_idx) * WIDTH +: WIDTH];
          o_mont_n     <= i_n;
          owner        <= pick_idx;
          o_gnt        <= pick_gnt;
          o_mont_start <= 1'b1;
          state        <= S_ISSUE;
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer == TW'(TIMEOUT) ? timer : timer + 1'b1;
          if (i_mont_finish) begin
            o_result <= i_mont_result;
            o_done   <= owner_oh;
            state    <= S_DONE;
          end else if (timer == TW'(TIMEOUT)) begin
            o_result <= '0;
            o_done   <= owner_oh;
            o_err    <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          rr_ptr <= owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule
